// File: rtl/sysref_sync_gen.sv
// sysref_sync_gen: measures the period of an asynchronous SYSREF and locks
// after LOCK_CNT consecutive matching periods. Once locked, each edge that
// matches the locked period fires one delayed sync pulse per channel.
//
// Ports:
//   clk        PL fabric clock, all logic on its rising edge
//   rst        asynchronous active-high reset
//   sysref_in  SYSREF level from the input buffer, asynchronous to clk
//   arm        one-cycle pulse that (re)starts acquisition from any state
//   dly        per-channel delay, channel c in bits [c*DLY_W +: DLY_W]
//   sync_out   per-channel one-cycle sync pulse, 1+dly[c] cycles after edge
//   locked     high while the tracker is in the LOCKED state
//   period     last measured SYSREF period in clk cycles
//   err        one-cycle pulse on period mismatch or loss of SYSREF
//   err_cnt    saturating count of err pulses (only when SYSREF_ERR_CNT_EN
//              is defined; cleared by rst and by arm)
//
// Optional build macro: SYSREF_ERR_CNT_EN adds the err_cnt port and counter.

module sysref_sync_gen #(
  parameter int N_CH     = 2,
  parameter int DLY_W    = 8,
  parameter int PERIOD_W = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sysref_in,
  input  logic                  arm,
  input  logic [N_CH*DLY_W-1:0] dly,
  output logic [N_CH-1:0]       sync_out,
  output logic                  locked,
  output logic [PERIOD_W-1:0]   period,
  output logic                  err
`ifdef SYSREF_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [7:0] LOCK_M = 8'(LOCK_CNT);

  state_t              state;
  logic                s1;
  logic                s2;
  logic                s3;
  logic                sr_edge;
  logic [PERIOD_W-1:0] cnt;
  logic [7:0]          match;
  logic [7:0]          match_nxt;
  logic                cnt_sat;
  logic                period_ok;
  logic                qualify;
  logic                mismatch;
  logic                sat_err;
  logic                cancel;

  // ---------------------------------------------------------------------
  // Input synchronizer. s1/s2 resolve metastability, s3 is the previous
  // synchronized level so a held-high SYSREF gives a single edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sysref_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sr_edge = s2 & ~s3;

  // ---------------------------------------------------------------------
  // Period counter. Restarts at 1 on every edge so that on the next edge
  // it holds the edge-to-edge distance in clk cycles. It sticks at
  // all-ones, which is the loss-of-SYSREF indication.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (sr_edge) begin
      cnt <= PERIOD_W'(1);
    end else if (!cnt_sat) begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

  assign cnt_sat   = &cnt;
  assign period_ok = (cnt == period);

  // ---------------------------------------------------------------------
  // Per-cycle event decode. arm overrides everything, so an edge in the
  // same cycle as arm neither qualifies nor flags a mismatch. An edge
  // takes precedence over counter saturation.
  // ---------------------------------------------------------------------
  always_comb begin
    qualify  = 1'b0;
    mismatch = 1'b0;
    sat_err  = 1'b0;
    if (!arm) begin
      if (sr_edge) begin
        if (state == LOCKED) begin
          qualify  = period_ok;
          mismatch = ~period_ok;
        end
      end else if (cnt_sat && (state == TRACK || state == LOCKED)) begin
        sat_err = 1'b1;
      end
    end
    cancel = arm | mismatch | sat_err;
  end

  // Match count after a TRACK edge: the first measurement or any new
  // period restarts the run at 1; a repeat of the stored period extends it.
  always_comb begin
    match_nxt = 8'd1;
    if (match != 8'd0 && period_ok) begin
      match_nxt = match + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Acquisition / tracking FSM with registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      match  <= 8'd0;
      period <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (arm) begin
        state  <= ACQ;
        match  <= 8'd0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          ACQ: begin
            // The first edge only gives a reference point for cnt.
            if (sr_edge) begin
              state <= TRACK;
              match <= 8'd0;
            end
          end
          TRACK: begin
            if (sr_edge) begin
              if (match == 8'd0 || !period_ok) begin
                period <= cnt;
              end
              match <= match_nxt;
              if (match_nxt >= LOCK_M) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (sat_err) begin
              err   <= 1'b1;
              state <= ACQ;
              match <= 8'd0;
            end
          end
          LOCKED: begin
            if (mismatch) begin
              // The off-period edge becomes the first sample of a new run.
              err    <= 1'b1;
              locked <= 1'b0;
              period <= cnt;
              match  <= 8'd1;
              state  <= TRACK;
            end else if (sat_err) begin
              err    <= 1'b1;
              locked <= 1'b0;
              match  <= 8'd0;
              state  <= ACQ;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel sync delay. A qualifying edge loads dly[c]; the pulse is
  // emitted when the countdown expires. A new qualifying edge reloads the
  // countdown, so at most one pulse is ever pending per channel.
  // ---------------------------------------------------------------------
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DLY_W-1:0] dly_c;
    logic [DLY_W-1:0] dcnt;
    logic             act;
    logic             pulse;

    assign dly_c = dly[c*DLY_W +: DLY_W];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dcnt  <= '0;
        act   <= 1'b0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (cancel) begin
          act <= 1'b0;
        end else if (qualify) begin
          if (dly_c == '0) begin
            pulse <= 1'b1;
            act   <= 1'b0;
          end else begin
            dcnt <= dly_c;
            act  <= 1'b1;
          end
        end else if (act) begin
          if (dcnt == DLY_W'(1)) begin
            pulse <= 1'b1;
            act   <= 1'b0;
          end else begin
            dcnt <= dcnt - DLY_W'(1);
          end
        end
      end
    end

    assign sync_out[c] = pulse;
  end

`ifdef SYSREF_ERR_CNT_EN
  // Counts the registered err pulse, so an arm arriving while err is high
  // clears the count instead of letting that pulse through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 16'd0;
    end else if (arm) begin
      err_cnt <= 16'd0;
    end else if (err && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sysref_sync_gen.sv
// Bench for sysref_sync_gen: table of per-edge SYSREF windows with expected
// err/locked/period/sync values, plus hand sequences for IDLE, loss of
// SYSREF, err_cnt (when SYSREF_ERR_CNT_EN is defined) and mid-run reset.

module tb_sysref_sync_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        sysref_in;
  logic        arm;
  logic [15:0] dly;
  logic [1:0]  sync_out;
  logic        locked;
  logic [15:0] period;
  logic        err;
`ifdef SYSREF_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  sysref_sync_gen #(
    .N_CH(2),
    .DLY_W(8),
    .PERIOD_W(16),
    .LOCK_CNT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sysref_in(sysref_in),
    .arm(arm),
    .dly(dly),
    .sync_out(sync_out),
    .locked(locked),
    .period(period),
    .err(err)
`ifdef SYSREF_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  // One record per SYSREF rising edge. gap = cycles until the next rise.
  // Effects of the edge are visible 3 ticks after the rise; a sync on
  // channel c is visible 3+dly[c] ticks after the rise.
  typedef struct {
    int gap;
    int d0;
    int d1;
    int arm_at_edge;
    int e_err;
    int e_lock;
    int e_per;
    int e_s0;
    int e_s1;
  } vec_t;

  vec_t v[28];
  int   total = 0;
  int   bad = 0;
  int   cur_vec = 0;
  int   cur_i = 0;
  int   prev_lock = 0;
  int   prev_per = 0;

  function automatic vec_t mk(int gap, int d0, int d1, int a, int e_err,
                              int e_lock, int e_per, int e_s0, int e_s1);
    vec_t r;
    r.gap = gap; r.d0 = d0; r.d1 = d1; r.arm_at_edge = a;
    r.e_err = e_err; r.e_lock = e_lock; r.e_per = e_per;
    r.e_s0 = e_s0; r.e_s1 = e_s1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s vec=%0d tick=%0d got=%0d want=%0d",
               name, cur_vec, cur_i, act, exp);
    end
  endtask

  task automatic apply(int lo, int hi);
    for (int k = lo; k <= hi; k++) begin
      cur_vec   = k;
      dly       = {8'(v[k].d1), 8'(v[k].d0)};
      sysref_in = 1'b1;
      for (int i = 1; i <= v[k].gap; i++) begin
        cur_i = i;
        tick();
        if (i == 3) arm = 1'b0;
        if (i == 4) sysref_in = 1'b0;
        chk("err", int'(err), (i == 3 && v[k].e_err != 0) ? 1 : 0);
        chk("locked", int'(locked), (i < 3) ? prev_lock : v[k].e_lock);
        chk("period", int'(period), (i < 3) ? prev_per : v[k].e_per);
        chk("sync0", int'(sync_out[0]),
            (v[k].e_s0 != 0 && i == 3 + v[k].d0) ? 1 : 0);
        chk("sync1", int'(sync_out[1]),
            (v[k].e_s1 != 0 && i == 3 + v[k].d1) ? 1 : 0);
        // arm is held through the cycle in which the edge is seen
        if (i == 2 && v[k].arm_at_edge != 0) arm = 1'b1;
      end
      prev_lock = v[k].e_lock;
      prev_per  = v[k].e_per;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog tick=%0d", cur_i);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_err;
    int nsync;

    // lock at 32, two qualifying edges, then an early edge at 30
    v[0]  = mk(32, 0, 5, 0, 0, 0, 0, 0, 0);   // ACQ -> TRACK
    v[1]  = mk(32, 0, 5, 0, 0, 0, 32, 0, 0);  // match 1
    v[2]  = mk(32, 0, 5, 0, 0, 0, 32, 0, 0);  // match 2
    v[3]  = mk(32, 0, 5, 0, 0, 0, 32, 0, 0);  // match 3
    v[4]  = mk(32, 0, 5, 0, 0, 1, 32, 0, 0);  // match 4 -> LOCKED, no sync
    v[5]  = mk(32, 0, 5, 0, 0, 1, 32, 1, 1);  // first qualifying edge
    v[6]  = mk(30, 0, 5, 0, 0, 1, 32, 1, 1);
    v[7]  = mk(32, 0, 5, 0, 1, 0, 30, 0, 0);  // edge at 30: err, back to TRACK
    v[8]  = mk(32, 0, 5, 0, 0, 0, 32, 0, 0);  // 32 != 30: new run, match 1
    v[9]  = mk(32, 0, 5, 0, 0, 0, 32, 0, 0);
    v[10] = mk(32, 0, 5, 0, 0, 0, 32, 0, 0);
    v[11] = mk(32, 0, 5, 0, 0, 1, 32, 0, 0);  // relock
    v[12] = mk(16, 0, 5, 0, 0, 1, 32, 1, 1);
    // move to period 16
    v[13] = mk(16, 0, 5, 0, 1, 0, 16, 0, 0);
    v[14] = mk(16, 0, 5, 0, 0, 0, 16, 0, 0);
    v[15] = mk(16, 0, 5, 0, 0, 0, 16, 0, 0);
    v[16] = mk(16, 0, 5, 0, 0, 1, 16, 0, 0);
    // dly0=20 keeps being reloaded before it expires
    v[17] = mk(16, 20, 5, 0, 0, 1, 16, 0, 1);
    v[18] = mk(16, 20, 5, 0, 0, 1, 16, 0, 1);
    v[19] = mk(16, 20, 5, 0, 0, 1, 16, 0, 1);
    // dly0=10 fires at edge+11; dly1=18 would land inside the next window
    v[20] = mk(16, 10, 18, 0, 0, 1, 16, 1, 0);
    // arm with the edge: edge ignored, pending sync1 cancelled
    v[21] = mk(16, 10, 18, 1, 0, 0, 16, 0, 0);
    v[22] = mk(16, 0, 5, 0, 0, 0, 16, 0, 0);  // ACQ -> TRACK
    v[23] = mk(16, 0, 5, 0, 0, 0, 16, 0, 0);
    v[24] = mk(16, 0, 5, 0, 0, 0, 16, 0, 0);
    v[25] = mk(16, 0, 5, 0, 0, 0, 16, 0, 0);
    v[26] = mk(16, 0, 5, 0, 0, 1, 16, 0, 0);
    v[27] = mk(10, 0, 5, 0, 0, 1, 16, 1, 1);

    rst = 1'b1; sysref_in = 1'b0; arm = 1'b0; dly = 16'd0;
    #3;
    cur_vec = -1;
    chk("rst_sync", int'(sync_out), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_err", int'(err), 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // IDLE must ignore edges entirely
    for (int e = 0; e < 2; e++) begin
      sysref_in = 1'b1;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (i == 4) sysref_in = 1'b0;
      end
    end
    tick(); tick(); tick();
    chk("idle_period", int'(period), 0);
    chk("idle_locked", int'(locked), 0);

    arm = 1'b1; tick(); arm = 1'b0;
    tick(); tick();
    prev_lock = 0; prev_per = 0;
    apply(0, 27);

    // loss of SYSREF while locked: the v[27] edge reset cnt to 1 at tick 3
    // of its window, so cnt reaches all-ones after tick 65537 and err is
    // visible after tick 65538
    cur_vec = 200;
    first_err = -1;
    nsync = 0;
    for (int i = 11; i <= 70000; i++) begin
      cur_i = i;
      tick();
      if (sync_out != 2'b00) nsync++;
      if (first_err >= 0 && i == first_err + 1) begin
        chk("sat_err_single", int'(err), 0);
        chk("sat_locked", int'(locked), 0);
        break;
      end
      if (err && first_err < 0) first_err = i;
    end
    chk("sat_err_tick", first_err, 65538);
    chk("sat_no_sync", nsync, 0);
    chk("sat_period", int'(period), 16);

`ifdef SYSREF_ERR_CNT_EN
    // two period mismatches plus the loss-of-SYSREF error
    chk("err_cnt_three", int'(err_cnt), 3);
`endif
    arm = 1'b1; tick(); arm = 1'b0; tick();
`ifdef SYSREF_ERR_CNT_EN
    chk("err_cnt_arm", int'(err_cnt), 0);
`endif

    // after loss of SYSREF the tracker is in ACQ: relock from scratch
    prev_lock = 0; prev_per = 16;
    apply(22, 26);

    // qualifying edge, then reset while the dly1=5 sync is still pending
    cur_vec = 300;
    dly = {8'd5, 8'd0};
    sysref_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cur_i = i;
      tick();
      if (i == 3) chk("pre_rst_sync0", int'(sync_out[0]), 1);
      if (i == 4) sysref_in = 1'b0;
    end
    chk("pre_rst_locked", int'(locked), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sync", int'(sync_out), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_err", int'(err), 0);
    tick(); tick();
    rst = 1'b0;
    nsync = 0;
    for (int i = 8; i <= 14; i++) begin
      cur_i = i;
      tick();
      if (sync_out != 2'b00) nsync++;
    end
    chk("post_rst_no_sync", nsync, 0);
    chk("post_rst_locked", int'(locked), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysref_sync_gen.md
Name: sysref_sync_gen

Overview:
Multi-channel SYSREF alignment and sync-pulse generator for the RFSoC DDC design. It takes the single-ended PL SYSREF, which is asynchronous to `clk`, produced by the top-level differential input buffer, and measures its period. It declares lock after repeated matching periods. Once locked, it emits one delayed sync pulse per channel on each qualifying SYSREF edge, so per-channel DDC/NCO phase resets are aligned across ADC/DAC tiles.

Parameters:
N_CH, 2, number of sync output channels (1..16)
DLY_W, 8, width of each per-channel delay field
PERIOD_W, 16, width of period counter and measured period
LOCK_CNT, 4, consecutive matching periods required for lock (1..255)

Ports:
clk  in  1  PL fabric clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
sysref_in  in  1  SYSREF from input buffer; asynchronous to clk
arm  in  1  single-cycle pulse; (re)starts acquisition
dly  in  N_CH*DLY_W  per-channel delay; channel c uses bits [c*DLY_W +: DLY_W]
sync_out  out  N_CH  per-channel one-cycle sync pulse
locked  out  1  high while in LOCKED state
period  out  PERIOD_W  last measured SYSREF period in clk cycles
err  out  1  one-cycle pulse on period mismatch or loss of SYSREF

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: sync_out=0, locked=0, period=0, err=0. FSM=IDLE, all counters=0.
- Input path: two-flop synchronizer s1, s2, then s3 for edge detect. edge = s2 & ~s3.
  - edge is high in the 3rd clk after the first clk edge that samples sysref_in high.
  - A level held high produces exactly one edge.
- Period counter cnt:
  - Increments every cycle.
  - Set to 1 on edge.
  - On saturating at all-ones while in TRACK or LOCKED: err pulse, go to ACQ.
- FSM states IDLE, ACQ, TRACK, LOCKED:
  - IDLE: ignores edges. arm -> ACQ.
  - ACQ: edge -> TRACK, match=0.
  - TRACK, on edge:
    - If match=0: period<=cnt, match=1.
    - Else if cnt==period: match<=match+1.
    - Else: period<=cnt, match=1, no err.
    - When match reaches LOCK_CNT: -> LOCKED; locked rises the following cycle.
  - LOCKED, on edge:
    - If cnt==period: qualifying edge, starts sync delay counters.
    - If cnt!=period: err=1 for one cycle, locked<=0, period<=cnt, match=1, -> TRACK, all pending sync countdowns cancelled.
- arm in any state: -> ACQ, locked<=0, match=0, pending syncs cancelled. arm in the same cycle as edge: arm wins, the edge is discarded.
- Sync generation, per channel c:
  - On a qualifying edge, load down-counter with dly[c], sampled that cycle.
  - sync_out[c] is high exactly 1+dly[c] cycles after the edge cycle; dly=0 means the next cycle.
  - A new qualifying edge while the countdown is still running reloads the counter; the earlier pending pulse is dropped, never doubled.
  - Channels are fully independent.
- The edge that completes lock does not generate sync; the first sync comes from the next qualifying edge.
- Mid-operation reset clears everything immediately, with no pulse emitted.

Optional Feature:
- SYSREF_ERR_CNT_EN: adds output port err_cnt (out, 16), which counts err pulses.
  - Saturates at 0xFFFF.
  - Reset to 0 by rst and by arm; arm takes priority over a simultaneous err.
- Without the macro: err_cnt port and its logic are absent; err behaviour is unchanged.

Test Plan:
- Reset then arm, sysref period 32 cycles, LOCK_CNT=4, dly=0/5 -> period=32; locked rises the cycle after the 5th detected edge; the 6th edge gives sync_out[0] at edge+1 and sync_out[1] at edge+6, repeating every 32 cycles.
- Locked at period 32, one SYSREF edge arrives at 30 -> err one cycle, locked=0, period=30, no sync for that edge; a steady 32 period afterwards relocks after 4 further matching edges.
- Locked, sysref_in stuck low -> at cnt=0xFFFF, err pulse, state ACQ, locked=0, no sync_out.
- Period 16 with dly[0]=20 -> each qualifying edge reloads the counter; sync_out[0] never asserts. With dly[0]=10 -> a pulse every 16 cycles at edge+11.
- arm coincident with edge while LOCKED -> locked=0 next cycle, that edge ignored, pending syncs cancelled, reacquisition starts at the next edge.
- With SYSREF_ERR_CNT_EN, inject 3 mismatches -> err_cnt=3; arm -> err_cnt=0.
